// File: rtl/comp_bl_sched.sv
// Baseline read scheduler for the double-buffered component-tracker vector accumulators.
// Optional `COMP_SCHED_STATS_EN adds tri_count / resync_count statistics outputs.
module comp_bl_sched #(
    parameter int N_ANTS              = 32,
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int READ_LATENCY        = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sync,
    output logic                        rd_en,
    output logic [$clog2(N_ANTS)-1:0]   ant_a,
    output logic [$clog2(N_ANTS)-1:0]   ant_b,
    output logic                        buf_sel,
    output logic                        rd_vld,
    output logic                        last_triangle,
    output logic                        buf_sel_out,
`ifdef COMP_SCHED_STATS_EN
    output logic [31:0]                 tri_count,
    output logic [15:0]                 resync_count,
`endif
    output logic                        resync_err
);

    // state | meaning
    // IDLE  | no schedule running, waiting for the first sync
    // ISSUE | issuing one baseline read per cycle, taps 0..N_TAPS-1
    // GAP   | remainder of the window, no reads

    localparam int ANT_BITS = $clog2(N_ANTS);
    localparam int N_TAPS   = N_ANTS / 2 + 1;

    localparam logic [ANT_BITS-1:0]            ANT_LAST = ANT_BITS'(N_ANTS - 1);
    localparam logic [ANT_BITS-1:0]            TAP_LAST = ANT_BITS'(N_TAPS - 1);
    localparam logic [SERIAL_ACC_LEN_BITS-1:0] WIN_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [SERIAL_ACC_LEN_BITS-1:0] win_q, win_d;
    logic [ANT_BITS-1:0]           ant_q, ant_d;
    logic [ANT_BITS-1:0]           tap_q, tap_d;
    logic [ANT_BITS-1:0]           ant_b_q, ant_b_d;
    logic                          rd_en_q, rd_en_d;
    logic                          buf_sel_q, buf_sel_d;
    logic                          resync_err_q, resync_err_d;
    logic [READ_LATENCY-1:0]       vld_pipe_q, vld_pipe_d;
    logic [READ_LATENCY-1:0]       lt_pipe_q, lt_pipe_d;
    logic [READ_LATENCY-1:0]       bs_pipe_q, bs_pipe_d;
`ifdef COMP_SCHED_STATS_EN
    logic [31:0]                   tri_count_q, tri_count_d;
    logic [15:0]                   resync_count_q, resync_count_d;
`endif

    logic win_last;
    logic resync_hit;
    logic last_tri_int;

    assign win_last     = (win_q == WIN_LAST);
    assign resync_hit   = sync && (state_q != IDLE) && !win_last;
    assign last_tri_int = (state_q != IDLE) && (ant_q == ANT_LAST);

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        ant_d        = ant_q;
        tap_d        = tap_q;
        buf_sel_d    = buf_sel_q;
        resync_err_d = resync_err_q | resync_hit;

        // sync overrides every counter update and restarts at window 0, tap 0
        if (sync) begin
            state_d   = ISSUE;
            win_d     = '0;
            ant_d     = '0;
            tap_d     = '0;
            buf_sel_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ISSUE: begin
                    if (tap_q == TAP_LAST) begin
                        tap_d   = '0;
                        state_d = win_last ? ISSUE : GAP;
                    end else begin
                        tap_d = tap_q + 1'b1;
                    end
                end
                GAP: begin
                    if (win_last) begin
                        state_d = ISSUE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (state_q != IDLE) begin
                win_d = win_q + 1'b1;
                if (win_last) begin
                    ant_d = ant_q + 1'b1;
                    if (ant_q == ANT_LAST) begin
                        buf_sel_d = ~buf_sel_q;
                    end
                end
            end
        end

        rd_en_d = (state_d == ISSUE);
        ant_b_d = ant_d - tap_d;

        // delay lines: the cast drops the oldest stage
        vld_pipe_d = READ_LATENCY'({vld_pipe_q, rd_en_q});
        lt_pipe_d  = READ_LATENCY'({lt_pipe_q, last_tri_int});
        bs_pipe_d  = READ_LATENCY'({bs_pipe_q, buf_sel_q});
    end

`ifdef COMP_SCHED_STATS_EN
    always_comb begin
        tri_count_d    = tri_count_q;
        resync_count_d = resync_count_q;
        if (sync) begin
            tri_count_d = '0;
        end else if (buf_sel_d != buf_sel_q) begin
            tri_count_d = tri_count_q + 32'd1;
        end
        if (resync_hit && (resync_count_q != 16'hFFFF)) begin
            resync_count_d = resync_count_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            win_q          <= '0;
            ant_q          <= '0;
            tap_q          <= '0;
            ant_b_q        <= '0;
            rd_en_q        <= 1'b0;
            buf_sel_q      <= 1'b0;
            resync_err_q   <= 1'b0;
            vld_pipe_q     <= '0;
            lt_pipe_q      <= '0;
            bs_pipe_q      <= '0;
`ifdef COMP_SCHED_STATS_EN
            tri_count_q    <= '0;
            resync_count_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            ant_q          <= ant_d;
            tap_q          <= tap_d;
            ant_b_q        <= ant_b_d;
            rd_en_q        <= rd_en_d;
            buf_sel_q      <= buf_sel_d;
            resync_err_q   <= resync_err_d;
            vld_pipe_q     <= vld_pipe_d;
            lt_pipe_q      <= lt_pipe_d;
            bs_pipe_q      <= bs_pipe_d;
`ifdef COMP_SCHED_STATS_EN
            tri_count_q    <= tri_count_d;
            resync_count_q <= resync_count_d;
`endif
        end
    end

    assign rd_en         = rd_en_q;
    assign ant_a         = ant_q;
    assign ant_b         = ant_b_q;
    assign buf_sel       = buf_sel_q;
    assign resync_err    = resync_err_q;
    assign rd_vld        = vld_pipe_q[READ_LATENCY-1];
    assign last_triangle = lt_pipe_q[READ_LATENCY-1];
    assign buf_sel_out   = bs_pipe_q[READ_LATENCY-1];
`ifdef COMP_SCHED_STATS_EN
    assign tri_count     = tri_count_q;
    assign resync_count  = resync_count_q;
`endif

endmodule

// File: tb/tb_comp_bl_sched.sv
// Directed self-checking bench for comp_bl_sched with N_ANTS=4, 8-cycle windows, read latency 2.
module tb_comp_bl_sched;

    localparam int N_ANTS = 4;
    localparam int SAL    = 3;
    localparam int RL     = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       rd_en;
    logic [1:0] ant_a;
    logic [1:0] ant_b;
    logic       buf_sel;
    logic       rd_vld;
    logic       last_triangle;
    logic       buf_sel_out;
    logic       resync_err;
`ifdef COMP_SCHED_STATS_EN
    logic [31:0] tri_count;
    logic [15:0] resync_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comp_bl_sched #(
        .N_ANTS              (N_ANTS),
        .SERIAL_ACC_LEN_BITS (SAL),
        .READ_LATENCY        (RL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sync          (sync),
        .rd_en         (rd_en),
        .ant_a         (ant_a),
        .ant_b         (ant_b),
        .buf_sel       (buf_sel),
        .rd_vld        (rd_vld),
        .last_triangle (last_triangle),
        .buf_sel_out   (buf_sel_out),
`ifdef COMP_SCHED_STATS_EN
        .tri_count     (tri_count),
        .resync_count  (resync_count),
`endif
        .resync_err    (resync_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sync  = 1'b0;
        repeat (3) tick();
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (ant_a !== 2'd0) begin errors++; $display("FAIL reset_ant_a: got %0d expected 0", ant_a); end
        checks++; if (ant_b !== 2'd0) begin errors++; $display("FAIL reset_ant_b: got %0d expected 0", ant_b); end
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL reset_buf_sel: got %b expected 0", buf_sel); end
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld: got %b expected 0", rd_vld); end
        checks++; if (last_triangle !== 1'b0) begin errors++; $display("FAIL reset_last_triangle: got %b expected 0", last_triangle); end
        checks++; if (buf_sel_out !== 1'b0) begin errors++; $display("FAIL reset_buf_sel_out: got %b expected 0", buf_sel_out); end
        checks++; if (resync_err !== 1'b0) begin errors++; $display("FAIL reset_resync_err: got %b expected 0", resync_err); end
        rst_n = 1'b1;
        repeat (7) tick();
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL idle_no_read: got %b expected 0", rd_en); end
    endtask

    // sync during cycle k; windows 0 and 1 follow immediately
    task automatic test_basic();
        logic [1:0] eb [16];
        eb = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
               2'd1, 2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int c = 0; c < 16; c++) begin
            automatic int  i      = c % 8;
            automatic bit  exp_rd = (i < 3);
            automatic bit  exp_vl = (i >= 2) && (i <= 4);
            automatic logic [1:0] exp_a = 2'(c / 8);
            checks++; if (rd_en !== exp_rd) begin errors++; $display("FAIL basic_rd_en c=%0d: got %b expected %b", c, rd_en, exp_rd); end
            checks++; if (ant_a !== exp_a) begin errors++; $display("FAIL basic_ant_a c=%0d: got %0d expected %0d", c, ant_a, exp_a); end
            if (exp_rd) begin
                checks++; if (ant_b !== eb[c]) begin errors++; $display("FAIL basic_ant_b c=%0d: got %0d expected %0d", c, ant_b, eb[c]); end
            end
            checks++; if (rd_vld !== exp_vl) begin errors++; $display("FAIL basic_rd_vld c=%0d: got %b expected %b", c, rd_vld, exp_vl); end
            checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL basic_buf_sel c=%0d: got %b expected 0", c, buf_sel); end
            checks++; if (last_triangle !== 1'b0) begin errors++; $display("FAIL basic_last_tri c=%0d: got %b expected 0", c, last_triangle); end
            checks++; if (resync_err !== 1'b0) begin errors++; $display("FAIL basic_resync_err c=%0d: got %b expected 0", c, resync_err); end
            tick();
        end
    endtask

    // windows 2..4: last window of the triangle and the buffer swap
    task automatic test_triangle_swap();
        logic [1:0] eb [9];
        eb = '{2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2};
        for (int c = 0; c < 24; c++) begin
            automatic int  w       = 2 + c / 8;
            automatic int  i       = c % 8;
            automatic bit  exp_rd  = (i < 3);
            automatic bit  exp_vl  = (i >= 2) && (i <= 4);
            automatic bit  exp_bs  = (w == 4);
            automatic bit  exp_bso = (w == 4) && (i >= 2);
            automatic bit  exp_lt  = ((w == 3) && (i >= 2)) || ((w == 4) && (i < 2));
            automatic logic [1:0] exp_a = 2'(w % 4);
            checks++; if (rd_en !== exp_rd) begin errors++; $display("FAIL tri_rd_en w=%0d i=%0d: got %b expected %b", w, i, rd_en, exp_rd); end
            checks++; if (ant_a !== exp_a) begin errors++; $display("FAIL tri_ant_a w=%0d i=%0d: got %0d expected %0d", w, i, ant_a, exp_a); end
            if (exp_rd) begin
                checks++; if (ant_b !== eb[(w - 2) * 3 + i]) begin errors++; $display("FAIL tri_ant_b w=%0d i=%0d: got %0d expected %0d", w, i, ant_b, eb[(w - 2) * 3 + i]); end
            end
            checks++; if (rd_vld !== exp_vl) begin errors++; $display("FAIL tri_rd_vld w=%0d i=%0d: got %b expected %b", w, i, rd_vld, exp_vl); end
            checks++; if (buf_sel !== exp_bs) begin errors++; $display("FAIL tri_buf_sel w=%0d i=%0d: got %b expected %b", w, i, buf_sel, exp_bs); end
            checks++; if (buf_sel_out !== exp_bso) begin errors++; $display("FAIL tri_buf_sel_out w=%0d i=%0d: got %b expected %b", w, i, buf_sel_out, exp_bso); end
            checks++; if (last_triangle !== exp_lt) begin errors++; $display("FAIL tri_last_tri w=%0d i=%0d: got %b expected %b", w, i, last_triangle, exp_lt); end
            tick();
        end
    endtask

    // now at window 5 cycle 0 (ant_a=1, buf_sel=1); sync on its last cycle
    task automatic test_aligned_resync();
        repeat (7) tick();
        checks++; if (ant_a !== 2'd1 || buf_sel !== 1'b1) begin errors++; $display("FAIL align_pre: got ant_a=%0d buf_sel=%b expected 1/1", ant_a, buf_sel); end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL align_rd_en: got %b expected 1", rd_en); end
        checks++; if (ant_a !== 2'd0) begin errors++; $display("FAIL align_ant_a: got %0d expected 0", ant_a); end
        checks++; if (ant_b !== 2'd0) begin errors++; $display("FAIL align_ant_b0: got %0d expected 0", ant_b); end
        checks++; if (buf_sel !== 1'b0) begin errors++; $display("FAIL align_buf_sel: got %b expected 0", buf_sel); end
        checks++; if (resync_err !== 1'b0) begin errors++; $display("FAIL align_resync_err: got %b expected 0", resync_err); end
        checks++; if (buf_sel_out !== 1'b1) begin errors++; $display("FAIL align_bso_c0: got %b expected 1", buf_sel_out); end
        tick();
        checks++; if (ant_b !== 2'd3) begin errors++; $display("FAIL align_ant_b1: got %0d expected 3", ant_b); end
        checks++; if (buf_sel_out !== 1'b1) begin errors++; $display("FAIL align_bso_c1: got %b expected 1", buf_sel_out); end
        tick();
        checks++; if (ant_b !== 2'd2) begin errors++; $display("FAIL align_ant_b2: got %0d expected 2", ant_b); end
        checks++; if (buf_sel_out !== 1'b0) begin errors++; $display("FAIL align_bso_c2: got %b expected 0", buf_sel_out); end
        checks++; if (rd_vld !== 1'b1) begin errors++; $display("FAIL align_rd_vld_c2: got %b expected 1", rd_vld); end
    endtask

    // now at window 0 cycle 2; sync at cycle 4
    task automatic test_misaligned_resync();
        repeat (2) tick();
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL misalign_pre_rd_en: got %b expected 0", rd_en); end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL misalign_rd_en: got %b expected 1", rd_en); end
        checks++; if (ant_a !== 2'd0) begin errors++; $display("FAIL misalign_ant_a: got %0d expected 0", ant_a); end
        checks++; if (ant_b !== 2'd0) begin errors++; $display("FAIL misalign_ant_b: got %0d expected 0", ant_b); end
        checks++; if (resync_err !== 1'b1) begin errors++; $display("FAIL misalign_resync_err: got %b expected 1", resync_err); end
`ifdef COMP_SCHED_STATS_EN
        checks++; if (resync_count !== 16'd1) begin errors++; $display("FAIL misalign_resync_count: got %0d expected 1", resync_count); end
`endif
        repeat (8) tick();
        checks++; if (ant_a !== 2'd1 || rd_en !== 1'b1) begin errors++; $display("FAIL misalign_next_win: got ant_a=%0d rd_en=%b expected 1/1", ant_a, rd_en); end
        checks++; if (resync_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b expected 1", resync_err); end
    endtask

    task automatic test_reset_mid_issue();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        checks++; if (rd_en !== 1'b1 || ant_b !== 2'd3) begin errors++; $display("FAIL rstmid_tap1: got rd_en=%b ant_b=%0d expected 1/3", rd_en, ant_b); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL rstmid_rd_vld: got %b expected 0", rd_vld); end
        checks++; if (ant_a !== 2'd0 || ant_b !== 2'd0) begin errors++; $display("FAIL rstmid_ants: got %0d/%0d expected 0/0", ant_a, ant_b); end
        checks++; if (buf_sel !== 1'b0 || buf_sel_out !== 1'b0) begin errors++; $display("FAIL rstmid_bufsel: got %b/%b expected 0/0", buf_sel, buf_sel_out); end
        checks++; if (resync_err !== 1'b0) begin errors++; $display("FAIL rstmid_resync_err: got %b expected 0", resync_err); end
        checks++; if (last_triangle !== 1'b0) begin errors++; $display("FAIL rstmid_last_tri: got %b expected 0", last_triangle); end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++; if (rd_en !== 1'b0 || rd_vld !== 1'b0) begin errors++; $display("FAIL rstmid_quiet c=%0d: got rd_en=%b rd_vld=%b expected 0/0", c, rd_en, rd_vld); end
        end
    endtask

`ifdef COMP_SCHED_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (tri_count !== 32'd0 || resync_count !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", tri_count, resync_count); end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (32) tick();
        checks++; if (tri_count !== 32'd1) begin errors++; $display("FAIL stats_tri1: got %0d expected 1", tri_count); end
        repeat (32) tick();
        checks++; if (tri_count !== 32'd2) begin errors++; $display("FAIL stats_tri2: got %0d expected 2", tri_count); end
        checks++; if (buf_sel !== 1'b0 || ant_a !== 2'd0) begin errors++; $display("FAIL stats_win8: got buf_sel=%b ant_a=%0d expected 0/0", buf_sel, ant_a); end
        repeat (7) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        checks++; if (tri_count !== 32'd0) begin errors++; $display("FAIL stats_tri_sync: got %0d expected 0", tri_count); end
        checks++; if (resync_count !== 16'd0 || resync_err !== 1'b0) begin errors++; $display("FAIL stats_resync: got %0d/%b expected 0/0", resync_count, resync_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_triangle_swap();
        test_aligned_resync();
        test_misaligned_resync();
        test_reset_mid_issue();
`ifdef COMP_SCHED_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
